// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-channel, W-bit streaming multiplexer with round-robin
// arbitration and a single-entry registered output stage.
//
// Parameters:
//   N  - number of input channels (2..16)
//   W  - data width per channel (1..64)
//   SW - select width, derived as $clog2(N)
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   en         global enable; low blocks new grants (output still drains)
//   in_data    N*W packed channel data, channel i at [i*W +: W]
//   in_valid   per-channel request
//   in_ready   per-channel accept, combinational, one-hot or zero
//   in_last    end-of-packet marker (only when MUX_LOCK_EN is defined)
//   out_data   registered data of the granted channel
//   out_sel    registered index of the channel that supplied out_data
//   out_valid  registered output-valid
//   out_ready  consumer accept
//
// Optional feature macro: MUX_LOCK_EN
//   When defined, a granted beat with in_last low locks arbitration onto that
//   channel until the beat carrying in_last high is accepted.

module mux_rr_stream #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
`ifdef MUX_LOCK_EN
  input  logic [N-1:0]    in_last,
`endif
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  // Output register and arbiter pointer
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic          r_out_valid;
  logic [SW-1:0] r_last;

`ifdef MUX_LOCK_EN
  logic          r_lock;
  logic [SW-1:0] r_locked;
`endif

  logic [N-1:0]  w_req;
  logic [SW:0]   w_scan;
  logic [SW-1:0] w_grant;
  logic          w_found;
  logic          w_space;
  logic          w_load;
  logic [W-1:0]  w_gdata;

  // Requests eligible for arbitration; a held lock masks all but one channel
  always_comb begin
    w_req = in_valid;
`ifdef MUX_LOCK_EN
    if (r_lock) begin
      w_req = in_valid & (N'(1) << r_locked);
    end
`endif
  end

  // Round-robin scan starting just after the last granted index.
  // r_last < N and k <= N, so one conditional subtract wraps modulo N;
  // indices N..2^SW-1 are therefore never produced.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_scan  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_scan = {1'b0, r_last} + (SW+1)'(k);
      if (w_scan >= (SW+1)'(N)) begin
        w_scan = w_scan - (SW+1)'(N);
      end
      if (!w_found && w_req[w_scan[SW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_scan[SW-1:0];
      end
    end
  end

  // Output slot is free when empty or draining this cycle
  assign w_space = ~r_out_valid | out_ready;
  // Reset gating keeps in_ready low while rst is high
  assign w_load  = ~rst & en & w_space & w_found;

  // One-hot accept to the granted channel
  always_comb begin
    in_ready = '0;
    if (w_load) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  // Data of the granted channel
  always_comb begin
    w_gdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_grant == SW'(i)) begin
        w_gdata = in_data[i*W +: W];
      end
    end
  end

  // Output buffer and arbiter pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_last      <= SW'(N-1);
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gdata;
      r_out_sel   <= w_grant;
      r_last      <= w_grant;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef MUX_LOCK_EN
  // Packet lock: set on a non-final beat, cleared on the final beat.
  // en low produces no load, so a paused packet keeps its lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock   <= 1'b0;
      r_locked <= '0;
    end else if (w_load) begin
      if (in_last[w_grant]) begin
        r_lock <= 1'b0;
      end else begin
        r_lock   <= 1'b1;
        r_locked <= w_grant;
      end
    end
  end
`endif

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_stream.sv
module tb_mux_rr_stream;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
`ifdef MUX_LOCK_EN
  logic [N-1:0]    in_last;
`endif
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_valid;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]    dat [N];
  logic [N-1:0]    nxt_last = '0;
  logic [W+SW-1:0] sb_q [$];

  always #5 clk = ~clk;

  mux_rr_stream #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the edge, check in_ready, queue the expected beat
  task automatic step(input logic e, input logic [N-1:0] v, input logic ordy,
                      input logic [N-1:0] exp_rdy, input logic [W-1:0] exp_data,
                      input logic [SW-1:0] exp_sel);
    @(posedge clk); #1;
    en        = e;
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = dat[i];
`ifdef MUX_LOCK_EN
    in_last = nxt_last;
`endif
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_rdy != '0) sb_q.push_back({exp_data, exp_sel});
  endtask

  // Scoreboard monitor: compare every beat the consumer takes
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h sel %0d with nothing expected", out_data, out_sel);
      end else begin
        logic [W+SW-1:0] e;
        e = sb_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[W+SW-1:SW]));
        chk("out_sel",  32'(out_sel),  32'(e[SW-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dat[0] = 8'hA0; dat[1] = 8'hA1; dat[2] = 8'hA2; dat[3] = 8'hA3;
    rst = 1'b1; en = 1'b0; in_valid = '0; out_ready = 1'b0; in_data = '0;
`ifdef MUX_LOCK_EN
    in_last = '0;
`endif

    // Reset then idle; requests during reset are not accepted
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b1; in_valid = 4'b1111;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h00);
    chk("rst_out_sel",   32'(out_sel),   32'h0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = '0;

    // Full rotation 0,1,2,3,0 with out_ready high
    step(1'b1, 4'b1111, 1'b1, 4'b0001, 8'hA0, 2'd0);
    chk("latency_out_valid", 32'(out_valid), 32'h0);
    step(1'b1, 4'b1111, 1'b1, 4'b0010, 8'hA1, 2'd1);
    step(1'b1, 4'b1111, 1'b1, 4'b0100, 8'hA2, 2'd2);
    step(1'b1, 4'b1111, 1'b1, 4'b1000, 8'hA3, 2'd3);
    step(1'b1, 4'b1111, 1'b1, 4'b0001, 8'hA0, 2'd0);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);

    // Backpressure: 0x55 held for 3 cycles, then channel 1 follows
    dat[2] = 8'h55;
    step(1'b1, 4'b0100, 1'b0, 4'b0100, 8'h55, 2'd2);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'b0010, 1'b0, 4'b0000, 8'h00, 2'd0);
      chk("bp_out_data",  32'(out_data),  32'h55);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
    end
    step(1'b1, 4'b0010, 1'b1, 4'b0010, 8'hA1, 2'd1);
    dat[2] = 8'hA2;
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);

    // Sparse requests with wrap: after grant 2, 0011 gives 0,1,0
    step(1'b1, 4'b0100, 1'b1, 4'b0100, 8'hA2, 2'd2);
    step(1'b1, 4'b0011, 1'b1, 4'b0001, 8'hA0, 2'd0);
    step(1'b1, 4'b0011, 1'b1, 4'b0010, 8'hA1, 2'd1);
    step(1'b1, 4'b0011, 1'b1, 4'b0001, 8'hA0, 2'd0);

    // Enable gating: output drains, nothing is accepted
    step(1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00, 2'd0);
    step(1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00, 2'd0);
    chk("en_out_valid", 32'(out_valid), 32'h0);
    chk("en_hold_data", 32'(out_data),  32'hA0);
    chk("en_hold_sel",  32'(out_sel),   32'h0);

    // Channel 2 packet of 3 beats while channel 0 requests throughout
`ifdef MUX_LOCK_EN
    nxt_last = 4'b0000; step(1'b1, 4'b0101, 1'b1, 4'b0100, 8'hA2, 2'd2);
    nxt_last = 4'b0000; step(1'b1, 4'b0101, 1'b1, 4'b0100, 8'hA2, 2'd2);
    nxt_last = 4'b0100; step(1'b1, 4'b0101, 1'b1, 4'b0100, 8'hA2, 2'd2);
    nxt_last = 4'b0000; step(1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0, 2'd0);
`else
    nxt_last = 4'b0000; step(1'b1, 4'b0101, 1'b1, 4'b0100, 8'hA2, 2'd2);
    nxt_last = 4'b0000; step(1'b1, 4'b0101, 1'b1, 4'b0001, 8'hA0, 2'd0);
    nxt_last = 4'b0100; step(1'b1, 4'b0101, 1'b1, 4'b0100, 8'hA2, 2'd2);
    nxt_last = 4'b0000; step(1'b1, 4'b0001, 1'b1, 4'b0001, 8'hA0, 2'd0);
`endif
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);

    // Reset mid-stream discards the held beat
    step(1'b1, 4'b0010, 1'b0, 4'b0010, 8'hA1, 2'd1);
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 4'b1111;
    #1;
    chk("midrst_in_ready",  32'(in_ready),  32'h0);
    chk("midrst_held",      32'(out_valid), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = '0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_out_data",  32'(out_data),  32'h00);
    chk("midrst_out_sel",   32'(out_sel),   32'h0);

    // Pointer back at N-1: channel 0 wins over channel 3
    step(1'b1, 4'b1001, 1'b1, 4'b0001, 8'hA0, 2'd0);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);
    step(1'b1, 4'b0000, 1'b1, 4'b0000, 8'h00, 2'd0);
    chk("final_out_valid", 32'(out_valid), 32'h0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
